// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared codes, unit select indices and FSM states for the ALU control sequencer
package alu_ctrl_pkg;

   // R-type funct codes understood by the sequencer
   localparam logic [5:0] F_AND     = 6'b100100;
   localparam logic [5:0] F_OR      = 6'b100101;
   localparam logic [5:0] F_ADD     = 6'b100000;
   localparam logic [5:0] F_SUB     = 6'b100010;
   localparam logic [5:0] F_SLT     = 6'b101010;
   localparam logic [5:0] F_SRL     = 6'b000010;
   localparam logic [5:0] F_MUL     = 6'b011001;
   localparam logic [5:0] F_DIVU    = 6'b011011;
   localparam logic [5:0] F_MFHI    = 6'b010000;
   localparam logic [5:0] F_MFLO    = 6'b010010;
   // Internal codes: HILO_WR is only ever driven by the sequencer itself
   localparam logic [5:0] F_HILO_WR = 6'b111111;
   localparam logic [5:0] F_NOP     = 6'b000000;

   // Bit positions inside the one-hot unit_sel bus
   localparam int USEL_ALU    = 0;
   localparam int USEL_SHT    = 1;
   localparam int USEL_MULDIV = 2;
   localparam int USEL_MUX    = 3;

   typedef enum logic [2:0] {
      UC_NONE,
      UC_ALU,
      UC_SHT,
      UC_MULDIV,
      UC_MUX
   } unit_class_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WB
   } state_e;

   // Map a unit class onto its one-hot select; UC_NONE selects nothing
   function automatic logic [3:0] usel_onehot(input unit_class_e uc);
      logic [3:0] sel;
      sel = 4'b0000;
      case (uc)
         UC_ALU:    sel[USEL_ALU]    = 1'b1;
         UC_SHT:    sel[USEL_SHT]    = 1'b1;
         UC_MULDIV: sel[USEL_MULDIV] = 1'b1;
         UC_MUX:    sel[USEL_MUX]    = 1'b1;
         default:   sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational funct classifier feeding the sequencer FSM
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6
) (
   input  logic [FUNCT_W-1:0] funct_i,
   output unit_class_e        uclass_o,
   output logic               multi_o,
   output logic               illegal_o
);

   // Classify the funct; anything not listed (including the internal HILO_WR) is illegal
   always_comb begin
      uclass_o  = UC_NONE;
      multi_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct_i)
         FUNCT_W'(F_AND),
         FUNCT_W'(F_OR),
         FUNCT_W'(F_ADD),
         FUNCT_W'(F_SUB),
         FUNCT_W'(F_SLT):  uclass_o = UC_ALU;
         FUNCT_W'(F_SRL):  uclass_o = UC_SHT;
         FUNCT_W'(F_MUL),
         FUNCT_W'(F_DIVU): begin
            uclass_o = UC_MULDIV;
            multi_o  = 1'b1;
         end
         FUNCT_W'(F_MFHI),
         FUNCT_W'(F_MFLO): uclass_o = UC_MUX;
         FUNCT_W'(F_NOP):  uclass_o = UC_NONE;
         default:          illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - ALU control unit: registered decode plus MUL/DIV sequencing with HI/LO write
module alu_control_seq
   import alu_ctrl_pkg::*;
#(
   parameter int FUNCT_W    = 6,
   parameter int MUL_CYCLES = 32,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FUNCT_W-1:0] funct_in,
   input  logic               op_valid,
   output logic               op_ready,
   output logic [FUNCT_W-1:0] ctrl_code,
   output logic [3:0]         unit_sel,
   output logic               busy,
   output logic               hilo_we,
   output logic               done,
   output logic               illegal_op
);

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FUNCT_W-1:0] op_q, op_d;
   logic [FUNCT_W-1:0] ctrl_q, ctrl_d;
   logic [3:0]         usel_q, usel_d;
   logic               busy_q, busy_d;
   logic               hwe_q, hwe_d;
   logic               done_q, done_d;
   logic               ill_q, ill_d;

   unit_class_e        dec_class;
   logic               dec_multi;
   logic               dec_illegal;
   logic               accept;
   logic [CNT_W-1:0]   run_last;

   alu_ctrl_decode #(
      .FUNCT_W (FUNCT_W)
   ) u_decode (
      .funct_i   (funct_in),
      .uclass_o  (dec_class),
      .multi_o   (dec_multi),
      .illegal_o (dec_illegal)
   );

   assign op_ready = (state_q == ST_IDLE);
   assign accept   = op_valid && op_ready;
   // Run length follows the latched opcode, so funct_in is free to change during RUN
   assign run_last = (op_q == FUNCT_W'(F_DIVU)) ? DIV_LAST : MUL_LAST;

   // Next-state and next-output logic; every output register defaults to its idle value
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      ctrl_d  = FUNCT_W'(F_NOP);
      usel_d  = 4'b0000;
      busy_d  = 1'b0;
      hwe_d   = 1'b0;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (dec_illegal) begin
                  ill_d = 1'b1;
               end else if (dec_multi) begin
                  state_d             = ST_RUN;
                  op_d                = funct_in;
                  cnt_d               = '0;
                  ctrl_d              = funct_in;
                  usel_d[USEL_MULDIV] = 1'b1;
                  busy_d              = 1'b1;
               end else begin
                  ctrl_d = funct_in;
                  usel_d = usel_onehot(dec_class);
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            usel_d[USEL_MULDIV] = 1'b1;
            if (cnt_q == run_last) begin
               state_d = ST_WB;
               cnt_d   = '0;
               ctrl_d  = FUNCT_W'(F_HILO_WR);
               hwe_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               ctrl_d = op_q;
               busy_d = 1'b1;
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= FUNCT_W'(F_NOP);
         ctrl_q  <= FUNCT_W'(F_NOP);
         usel_q  <= 4'b0000;
         busy_q  <= 1'b0;
         hwe_q   <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         ctrl_q  <= ctrl_d;
         usel_q  <= usel_d;
         busy_q  <= busy_d;
         hwe_q   <= hwe_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
      end
   end

   assign ctrl_code  = ctrl_q;
   assign unit_sel   = usel_q;
   assign busy       = busy_q;
   assign hilo_we    = hwe_q;
   assign done       = done_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// tb/tb_alu_control_seq.sv - directed self-checking bench for alu_control_seq
module tb_alu_control_seq;

   logic       clk;
   logic       reset;
   logic [5:0] funct_in;
   logic       op_valid;
   logic       op_ready;
   logic [5:0] ctrl_code;
   logic [3:0] unit_sel;
   logic       busy;
   logic       hilo_we;
   logic       done;
   logic       illegal_op;

   int checks;
   int errors;

   alu_control_seq #(
      .FUNCT_W    (6),
      .MUL_CYCLES (32),
      .DIV_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .funct_in   (funct_in),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .ctrl_code  (ctrl_code),
      .unit_sel   (unit_sel),
      .busy       (busy),
      .hilo_we    (hilo_we),
      .done       (done),
      .illegal_op (illegal_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view: {ctrl_code, unit_sel, busy, hilo_we, done, illegal_op, op_ready}
   function automatic logic [31:0] ev(input logic [5:0] c, input logic [3:0] u,
                                      input logic b, input logic h, input logic d,
                                      input logic i, input logic r);
      return {17'd0, c, u, b, h, d, i, r};
   endfunction

   function automatic logic [31:0] obs();
      return {17'd0, ctrl_code, unit_sel, busy, hilo_we, done, illegal_op, op_ready};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a multi-cycle op now, then check len RUN cycles, the WB cycle and the return to idle
   task automatic run_multi(input logic [5:0] code, input int len, input string tag);
      funct_in = code;
      op_valid = 1'b1;
      tick();
      for (int i = 0; i < len; i++) begin
         check($sformatf("%s_run%0d", tag, i), obs(), ev(code, 4'b0100, 1, 0, 0, 0, 0));
         funct_in = 6'($urandom);
         op_valid = 1'b1;
         tick();
      end
      check({tag, "_wb"}, obs(), ev(6'b111111, 4'b0100, 0, 1, 1, 0, 0));
      op_valid = 1'b0;
      tick();
      check({tag, "_idle"}, obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));
   endtask

   logic [5:0] b2b_code [4];
   logic [3:0] b2b_sel  [4];

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      funct_in = 6'b000000;
      op_valid = 1'b0;
      b2b_code = '{6'b100000, 6'b100010, 6'b000010, 6'b010000};
      b2b_sel  = '{4'b0001, 4'b0001, 4'b0010, 4'b1000};

      tick();
      tick();
      reset = 1'b0;
      check("reset", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));
      tick();
      check("idle", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));

      // ADD, SUB, SRL, MFHI on consecutive cycles
      for (int i = 0; i < 4; i++) begin
         funct_in = b2b_code[i];
         op_valid = 1'b1;
         tick();
         check($sformatf("b2b%0d", i), obs(), ev(b2b_code[i], b2b_sel[i], 0, 0, 1, 0, 1));
      end
      op_valid = 1'b0;
      tick();
      check("b2b_end", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));

      // MUL, 32 cycles, funct toggling mid-run
      run_multi(6'b011001, 32, "mul");

      // DIVU with 4 cycles and ADD held valid: ADD only accepted at N+6
      funct_in = 6'b011011;
      op_valid = 1'b1;
      tick();
      funct_in = 6'b100000;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("div_run%0d", i), obs(), ev(6'b011011, 4'b0100, 1, 0, 0, 0, 0));
         tick();
      end
      check("div_wb", obs(), ev(6'b111111, 4'b0100, 0, 1, 1, 0, 0));
      tick();
      check("div_n6", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));
      tick();
      check("div_add", obs(), ev(6'b100000, 4'b0001, 0, 0, 1, 0, 1));
      op_valid = 1'b0;
      tick();
      check("div_idle", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));

      // Unknown funct
      funct_in = 6'b111000;
      op_valid = 1'b1;
      tick();
      check("illegal", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 1, 1));
      op_valid = 1'b0;
      tick();
      check("illegal_clr", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));

      // Reset when counter reaches 10 during MUL
      funct_in = 6'b011001;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("abort_pre", obs(), ev(6'b011001, 4'b0100, 1, 0, 0, 0, 0));
      reset = 1'b1;
      tick();
      check("abort_reset", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));
      reset = 1'b0;
      tick();
      check("abort_idle", obs(), ev(6'b000000, 4'b0000, 0, 0, 0, 0, 1));
      run_multi(6'b011001, 32, "mul2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
